// File: rtl/dma_wr_engine.sv
// DMA write engine: drains a first-word-fall-through source into a memory
// write port, one word per cycle, for a captured base address and length.
module dma_wr_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              rclk,
    input  logic              rrst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  xfer_len,
    input  logic              empty,
    input  logic [31:0]       rd_data,
    output logic              rd_enable,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done
);

    localparam logic [LEN_W-1:0]  LenOne  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  pops_q, pops_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [LEN_W-1:0]  words_inc;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              pop;
    logic              accept;
    logic              last_accept;
    logic              start_ok;

    assign start_ok    = (state_q == StIdle) & start;
    assign accept      = mem_we_q & mem_ready;
    assign words_inc   = words_q + LenOne;
    assign last_accept = accept & (words_inc == len_q);
    // Pop only when the output register is free or being emptied this cycle.
    assign pop = (state_q == StXfer) & ~empty & (pops_q < len_q) & (~mem_we_q | mem_ready);

    // State register.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a start seen while busy has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (xfer_len != '0) ? StXfer : StDone;
                end
            end
            StXfer: begin
                if (last_accept) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode.
    always_comb begin
        rd_enable  = pop;
        busy       = (state_q == StXfer) | (state_q == StDone);
        done       = (state_q == StDone);
        mem_we     = mem_we_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        words_done = words_q;
    end

    // Datapath next values: a pop refills the write register in the same
    // cycle it is accepted, so full throughput has no bubbles.
    always_comb begin
        len_d    = len_q;
        pops_d   = pops_q;
        words_d  = words_q;
        mem_we_d = mem_we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (start_ok) begin
            len_d    = xfer_len;
            addr_d   = base_addr;
            pops_d   = '0;
            words_d  = '0;
            mem_we_d = 1'b0;
        end
        if (accept) begin
            addr_d   = addr_q + AddrOne;
            words_d  = words_inc;
            mem_we_d = 1'b0;
        end
        if (pop) begin
            pops_d   = pops_q + LenOne;
            wdata_d  = rd_data;
            mem_we_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            len_q    <= '0;
            pops_q   <= '0;
            words_q  <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            len_q    <= len_d;
            pops_q   <= pops_d;
            words_q  <= words_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

endmodule
